// File: rtl/mc_control_unit_if.sv
// rtl/mc_control_unit_if.sv - control-unit to datapath signal bundle
// master drives the datapath strobes; slave is the datapath side.
interface mc_control_unit_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       bcond;
  logic       mem_ready;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_source;
  logic [1:0] mem_to_reg;
  logic [2:0] alu_op;
  logic       is_halted;

  modport master (
    input  opcode, funct3, funct7_5, bcond, mem_ready,
    output ir_write, pc_write, pc_write_cond, reg_write, mem_read, mem_write,
           iord, alu_src_a, alu_src_b, pc_source, mem_to_reg, alu_op, is_halted
  );

  modport slave (
    output opcode, funct3, funct7_5, bcond, mem_ready,
    input  ir_write, pc_write, pc_write_cond, reg_write, mem_read, mem_write,
           iord, alu_src_a, alu_src_b, pc_source, mem_to_reg, alu_op, is_halted
  );
endinterface

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle RV32I control FSM
// Sequences IF/ID/EX/MEM/WB; strobes are decoded combinationally from the state register.
module mc_control_unit (
  input  logic                clk,
  input  logic                reset_n,
  mc_control_unit_if.master   bus
);
  // ALU op set: funct3 values pass through; SLT/SLTU are not in this ALU, so 010 is
  // the load/store address add and 011 is SUB.
  localparam logic [2:0] FUNCT3_ADD = 3'b000;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;
  localparam logic [2:0] FUNCT3_SUB = 3'b011;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t state;
  logic   known_op;

  // bcond gates the PC write in the datapath, not here
  logic unused_bcond;
  assign unused_bcond = bus.bcond;

  assign known_op = (bus.opcode == OP_R)      || (bus.opcode == OP_I)     ||
                    (bus.opcode == OP_LOAD)   || (bus.opcode == OP_STORE) ||
                    (bus.opcode == OP_BRANCH) || (bus.opcode == OP_JAL)   ||
                    (bus.opcode == OP_JALR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IF;
    end else begin
      case (state)
        S_IF:  if (bus.mem_ready) state <= S_ID;
        S_ID: begin
          if (bus.opcode == OP_ECALL) state <= S_HALT;
          else if (known_op)          state <= S_EX;
          else                        state <= S_IF;
        end
        S_EX: begin
          if (bus.opcode == OP_LOAD || bus.opcode == OP_STORE) state <= S_MEM;
          else if (bus.opcode == OP_BRANCH || !known_op)       state <= S_IF;
          else                                                 state <= S_WB;
        end
        S_MEM: begin
          if (bus.mem_ready) state <= (bus.opcode == OP_LOAD) ? S_WB : S_IF;
        end
        S_WB:    state <= S_IF;
        S_HALT:  state <= S_HALT;
        default: state <= S_IF;
      endcase
    end
  end

  always_comb begin
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.reg_write     = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.iord          = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'd0;
    bus.pc_source     = 1'b0;
    bus.mem_to_reg    = 2'd0;
    bus.alu_op        = FUNCT3_ADD;
    bus.is_halted     = 1'b0;
    if (reset_n) begin
      case (state)
        S_IF: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'd1;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        S_ID: bus.alu_src_b = 2'd2;
        S_EX: begin
          case (bus.opcode)
            OP_R: begin
              bus.alu_src_a = 1'b1;
              bus.alu_op    = (bus.funct3 == 3'b000 && bus.funct7_5) ? FUNCT3_SUB : bus.funct3;
            end
            OP_I: begin
              bus.alu_src_a = 1'b1;
              bus.alu_src_b = 2'd2;
              bus.alu_op    = bus.funct3;
            end
            OP_LOAD, OP_STORE: begin
              bus.alu_src_a = 1'b1;
              bus.alu_src_b = 2'd2;
              bus.alu_op    = (bus.opcode == OP_LOAD) ? FUNCT3_LW : FUNCT3_SW;
            end
            OP_BRANCH: begin
              bus.alu_src_a     = 1'b1;
              bus.alu_op        = bus.funct3;
              bus.pc_write_cond = 1'b1;
              bus.pc_source     = 1'b1;
            end
            OP_JAL: begin
              bus.pc_write  = 1'b1;
              bus.pc_source = 1'b1;
            end
            OP_JALR: begin
              bus.alu_src_a = 1'b1;
              bus.alu_src_b = 2'd2;
              bus.pc_write  = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          bus.iord      = 1'b1;
          bus.mem_read  = (bus.opcode == OP_LOAD);
          bus.mem_write = (bus.opcode == OP_STORE);
        end
        S_WB: begin
          bus.reg_write = 1'b1;
          if (bus.opcode == OP_LOAD)                             bus.mem_to_reg = 2'd1;
          else if (bus.opcode == OP_JAL || bus.opcode == OP_JALR) bus.mem_to_reg = 2'd2;
        end
        S_HALT:  bus.is_halted = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - directed checks of mc_control_unit output vectors
// Each step compares all outputs, packed, against a hand-built vector at the falling edge.
module tb_mc_control_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  mc_control_unit_if bus ();

  mc_control_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [16:0] vec;
  assign vec = {bus.is_halted, bus.ir_write, bus.pc_write, bus.pc_write_cond, bus.reg_write,
                bus.mem_read, bus.mem_write, bus.iord, bus.alu_src_a, bus.alu_src_b,
                bus.pc_source, bus.mem_to_reg, bus.alu_op};

  function automatic logic [16:0] mk(input logic h, ir, pw, pwc, rw, mr, mw, io, sa,
                                     input logic [1:0] sb, input logic ps,
                                     input logic [1:0] mtr, input logic [2:0] op);
    return {h, ir, pw, pwc, rw, mr, mw, io, sa, sb, ps, mtr, op};
  endfunction

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [16:0] exp);
    @(negedge clk);
    check(tag, vec, exp);
    @(posedge clk);
    #1;
  endtask

  logic [16:0] v_if_wait, v_if_rdy, v_id, v_ex_sub, v_ex_lw, v_ex_sw, v_ex_bne, v_ex_jal;
  logic [16:0] v_ex_jalr, v_ex_xori, v_mem_ld, v_mem_st, v_wb_alu, v_wb_ld, v_wb_jmp, v_halt;

  initial begin
    // fields: h ir pw pwc rw mr mw io sa sb ps mtr op
    v_if_wait = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd1, 0, 2'd0, 3'b000);
    v_if_rdy  = mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 2'd1, 0, 2'd0, 3'b000);
    v_id      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 0, 2'd0, 3'b000);
    v_ex_sub  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 2'd0, 3'b011);
    v_ex_xori = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 3'b100);
    v_ex_lw   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 3'b010);
    v_ex_sw   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 3'b010);
    v_ex_bne  = mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 2'd0, 1, 2'd0, 3'b001);
    v_ex_jal  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 3'b000);
    v_ex_jalr = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 3'b000);
    v_mem_ld  = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 0, 2'd0, 3'b000);
    v_mem_st  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 0, 2'd0, 3'b000);
    v_wb_alu  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 3'b000);
    v_wb_ld   = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0, 0, 2'd1, 3'b000);
    v_wb_jmp  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0, 0, 2'd2, 3'b000);
    v_halt    = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 3'b000);

    bus.opcode = 7'b0110011; bus.funct3 = 3'b000; bus.funct7_5 = 1'b0;
    bus.bcond = 1'b0; bus.mem_ready = 1'b1;

    step("reset_a", 17'h0);
    step("reset_b", 17'h0);
    reset_n = 1'b1;
    bus.mem_ready = 1'b0;
    step("if_wait", v_if_wait);
    bus.mem_ready = 1'b1;
    step("if_rdy", v_if_rdy);

    // SUB: IF ID EX WB
    bus.opcode = 7'b0110011; bus.funct3 = 3'b000; bus.funct7_5 = 1'b1;
    step("sub_id", v_id);
    step("sub_ex", v_ex_sub);
    step("sub_wb", v_wb_alu);
    step("sub_if", v_if_rdy);

    // XORI: funct7_5 set must not turn it into SUB-like behaviour
    bus.opcode = 7'b0010011; bus.funct3 = 3'b100; bus.funct7_5 = 1'b1;
    step("xori_id", v_id);
    step("xori_ex", v_ex_xori);
    step("xori_wb", v_wb_alu);
    step("xori_if", v_if_rdy);

    // LOAD with two wait cycles in MEM
    bus.opcode = 7'b0000011; bus.funct3 = 3'b010; bus.funct7_5 = 1'b0;
    step("ld_id", v_id);
    step("ld_ex", v_ex_lw);
    bus.mem_ready = 1'b0;
    step("ld_mem_w0", v_mem_ld);
    step("ld_mem_w1", v_mem_ld);
    bus.mem_ready = 1'b1;
    step("ld_mem_rdy", v_mem_ld);
    bus.mem_ready = 1'b0;
    step("ld_wb", v_wb_ld);
    step("ld_if", v_if_wait);
    bus.mem_ready = 1'b1;
    step("ld_if_rdy", v_if_rdy);

    // STORE zero-wait
    bus.opcode = 7'b0100011;
    step("st_id", v_id);
    step("st_ex", v_ex_sw);
    step("st_mem", v_mem_st);
    step("st_if", v_if_rdy);

    // BNE taken and not taken look identical
    for (int b = 1; b >= 0; b--) begin
      bus.opcode = 7'b1100011; bus.funct3 = 3'b001; bus.bcond = b[0];
      step("bne_id", v_id);
      step("bne_ex", v_ex_bne);
      step("bne_if", v_if_rdy);
    end

    // JAL and JALR
    bus.opcode = 7'b1101111;
    step("jal_id", v_id);
    step("jal_ex", v_ex_jal);
    step("jal_wb", v_wb_jmp);
    step("jal_if", v_if_rdy);
    bus.opcode = 7'b1100111; bus.funct3 = 3'b000;
    step("jalr_id", v_id);
    step("jalr_ex", v_ex_jalr);
    step("jalr_wb", v_wb_jmp);
    step("jalr_if", v_if_rdy);

    // unknown opcode behaves as NOP
    bus.opcode = 7'b1111111;
    step("nop_id", v_id);
    step("nop_if", v_if_rdy);

    // reset during a LOAD memory wait
    bus.opcode = 7'b0000011; bus.funct3 = 3'b010;
    step("rl_id", v_id);
    step("rl_ex", v_ex_lw);
    bus.mem_ready = 1'b0;
    step("rl_mem", v_mem_ld);
    reset_n = 1'b0;
    #1;
    check("rl_async", vec, 17'h0);
    step("rl_reset", 17'h0);
    reset_n = 1'b1;
    step("rl_if_after", v_if_wait);
    bus.mem_ready = 1'b1;
    step("rl_if_rdy", v_if_rdy);

    // ECALL halts; random inputs do not disturb HALT
    bus.opcode = 7'b1110011; bus.funct3 = 3'b000;
    step("ecall_id", v_id);
    for (int i = 0; i < 10; i++) begin
      bus.opcode    = 7'($urandom);
      bus.funct3    = 3'($urandom);
      bus.mem_ready = 1'($urandom);
      bus.bcond     = 1'($urandom);
      step("halt", v_halt);
    end
    reset_n = 1'b0;
    step("halt_reset", 17'h0);
    reset_n = 1'b1;
    bus.mem_ready = 1'b1;
    step("halt_cleared", v_if_rdy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle control FSM for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives the ALU's `alu_op` and operand selects, and it drives the PC, IR, register-file and memory strobes. It sits directly upstream of the ALU and consumes the ALU's `bcond` for conditional branches. It waits on a single-bit memory ready handshake.

## Interface
Parameters: none; `alu_op` codes are the `FUNCT3_*` macros of `alu_func.v`.
- `clk` in 1: rising-edge clock
- `reset_n` in 1: asynchronous, active-low reset
- `opcode` in 7: IR[6:0]
- `funct3` in 3: IR[14:12]
- `funct7_5` in 1: IR[30]
- `bcond` in 1: branch condition from ALU
- `mem_ready` in 1: memory completes current access this cycle
- `ir_write`, `pc_write`, `pc_write_cond`, `reg_write`, `mem_read`, `mem_write`, `iord` out 1: datapath strobes (`iord`: 0=PC addr, 1=ALUOut addr)
- `alu_src_a` out 1: 0=old_pc, 1=rs1
- `alu_src_b` out 2: 0=rs2, 1=const 4, 2=imm
- `pc_source` out 1: 0=ALU result, 1=ALUOut
- `mem_to_reg` out 2: 0=ALUOut, 1=MDR, 2=old_pc+4
- `alu_op` out 3: ALU operation
- `is_halted` out 1: core halted (sticky)

## Operation
- State register only: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. It updates on posedge `clk`.
- Outputs are combinational from state, opcode, funct fields and `mem_ready`.
- Unlisted strobes are 0. The default is `alu_op`=ADD with selects at 0.
- **IF**
  - `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, ADD.
  - `ir_write` = `pc_write` = `mem_ready`, `pc_source`=0.
  - The datapath latches old_pc on `ir_write`.
  - Stay in IF until `mem_ready`, then go to ID.
- **ID**
  - `alu_src_a`=0, `alu_src_b`=2, ADD. This produces the target in ALUOut.
  - ECALL (1110011) goes to HALT.
  - Unknown opcode goes to IF (NOP).
  - Otherwise go to EX.
- **EX**
  - R (0110011): `alu_src_a`=1, `alu_src_b`=0. `alu_op` comes from `funct3`; `funct3`=000 with `funct7_5`=1 gives SUB. Next state WB.
  - I-ALU (0010011): `alu_src_a`=1, `alu_src_b`=2, `alu_op` from `funct3` (never SUB). Next state WB.
  - LOAD (0000011) / STORE (0100011): `alu_src_a`=1, `alu_src_b`=2, `alu_op`=LW / SW. Next state MEM.
  - BRANCH (1100011): `alu_src_a`=1, `alu_src_b`=0, `alu_op`=BEQ/BNE/BLT/BGE from `funct3`, `pc_write_cond`=1, `pc_source`=1. Next state IF. The datapath gates the PC write by `bcond`; this block's strobes do not depend on `bcond`.
  - JAL (1101111): `pc_write`=1, `pc_source`=1. Next state WB.
  - JALR (1100111): `alu_src_a`=1, `alu_src_b`=2, ADD, `pc_write`=1, `pc_source`=0. Next state WB.
- **MEM**
  - `iord`=1. LOAD holds `mem_read`=1; STORE holds `mem_write`=1.
  - Hold until `mem_ready`. LOAD then goes to WB; STORE goes to IF.
- **WB**
  - `reg_write`=1.
  - `mem_to_reg`: 0 for R/I-ALU, 1 for LOAD, 2 for JAL/JALR.
  - Next state IF.
- **HALT**
  - All strobes 0, `is_halted`=1.
  - Stays in HALT regardless of inputs until reset.

## Timing
- Reset
  - `reset_n` low immediately forces state IF, regardless of `clk`.
  - While `reset_n` is low, all strobes are forced 0 and `is_halted`=0.
  - The first fetch request is issued in the cycle after `reset_n` rises.
- Reset asserted mid memory wait aborts the access. No `reg_write` or `pc_write` is issued.
- Memory handshake
  - The request is held constant until the cycle `mem_ready`=1.
  - Zero-wait is legal: `mem_ready` in the first cycle gives a 1-cycle IF or MEM.
  - `mem_ready` is ignored outside IF and MEM.
- Minimum latency with zero-wait memory:
  - BRANCH 3 cycles
  - R, I-ALU, STORE, JAL, JALR 4 cycles
  - LOAD 5 cycles
  - ECALL reaches HALT after 2 cycles
- Each wait cycle adds 1 cycle.
- `opcode`/`funct` inputs are sampled only in ID/EX/MEM/WB. The IR is stable there.

## Test plan
- `reset_n` low during a LOAD's MEM wait → state IF next edge, all strobes 0, `is_halted`=0. After release, IF asserts `mem_read`=1, `iord`=0.
- SUB (opcode 0110011, `funct3`=000, `funct7_5`=1), `mem_ready`=1 → IF,ID,EX,WB in 4 cycles. EX: `alu_op`=FUNCT3_SUB, `alu_src_a`=1, `alu_src_b`=0. WB: `reg_write`=1, `mem_to_reg`=0.
- LOAD, `mem_ready` low 2 cycles in MEM → MEM lasts 3 cycles with `mem_read`=1, `iord`=1 held. WB: `mem_to_reg`=1. Total 7 cycles.
- BNE (`funct3`=001) with `bcond`=1, then `bcond`=0 → both: EX `alu_op`=FUNCT3_BNE, `pc_write_cond`=1, `pc_source`=1, back to IF after 3 cycles.
- JAL → EX `pc_write`=1, `pc_source`=1. WB `reg_write`=1, `mem_to_reg`=2. 4 cycles.
- ECALL → HALT after ID, `is_halted`=1 and all strobes 0 for 10 cycles of random `mem_ready`/opcode. Cleared only by `reset_n`.
